// File: rtl/flow_bus_deserializer.sv
// flow_bus_deserializer: packs DATA_NUM consecutive upstream words into one wide word.
// The first accepted word lands in the most significant slot. A completed word leaves as a
// one-cycle valid pulse through an optional register pipeline. The upstream ready can be
// taken from down_ready, optionally delayed, and is gated by enable and reset.
module flow_bus_deserializer #(
    parameter int unsigned DATA_WIDTH      = 8,
    parameter int unsigned DATA_NUM        = 2,
    parameter int unsigned REG_DEPTH_DATA  = 0,
    parameter int unsigned REG_DEPTH_READY = 0,
    parameter int unsigned USE_READY       = 1,
    parameter int unsigned USE_ENABLE      = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           enable,
    output logic                           up_ready,
    input  logic                           up_valid,
    input  logic [DATA_WIDTH-1:0]          up_data,
    input  logic                           down_ready,
    output logic                           down_valid,
    output logic [DATA_WIDTH*DATA_NUM-1:0] down_data
);

    localparam int unsigned CntW = (DATA_NUM > 2) ? $clog2(DATA_NUM) : 1;
    localparam int unsigned OutW = DATA_WIDTH * DATA_NUM;
    localparam logic [CntW-1:0] CntLast = CntW'(DATA_NUM - 1);

    logic            w_ready_src;
    logic            w_ready_last;
    logic            w_enable;
    logic            w_accept;
    int unsigned     w_slot_lsb;
    logic [OutW-1:0] w_merged;

    logic [CntW-1:0] r_cnt;
    logic [OutW-1:0] r_buf;
    // Index 0 is the output register; higher indices are the extra delay stages.
    logic            r_pv [REG_DEPTH_DATA+1];
    logic [OutW-1:0] r_pd [REG_DEPTH_DATA+1];

    assign w_ready_src = (USE_READY != 0) ? down_ready : 1'b1;
    assign w_enable    = (USE_ENABLE != 0) ? enable : 1'b1;

    if (REG_DEPTH_READY == 0) begin : g_rdy_comb
        assign w_ready_last = w_ready_src;
    end else begin : g_rdy_pipe
        logic [REG_DEPTH_READY-1:0] r_rdy;

        // Delay line on the ready path; cleared so up_ready stays low just after reset.
        always_ff @(posedge clk) begin
            if (!rst) begin
                r_rdy <= '0;
            end else begin
                r_rdy[0] <= w_ready_src;
                for (int unsigned i = 1; i < REG_DEPTH_READY; i++) begin
                    r_rdy[i] <= r_rdy[i-1];
                end
            end
        end

        assign w_ready_last = r_rdy[REG_DEPTH_READY-1];
    end

    assign up_ready = w_ready_last & w_enable & rst;
    assign w_accept = up_valid & up_ready;

    // Assembly buffer with the incoming word dropped into its slot (MS slot first).
    always_comb begin
        w_slot_lsb = (DATA_NUM - 1 - 32'(r_cnt)) * DATA_WIDTH;
        w_merged   = r_buf;
        w_merged[w_slot_lsb +: DATA_WIDTH] = up_data;
    end

    // Word counter, partial buffer, output register and output delay stages.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
            r_buf <= '0;
            for (int unsigned i = 0; i <= REG_DEPTH_DATA; i++) begin
                r_pv[i] <= 1'b0;
                r_pd[i] <= '0;
            end
        end else begin
            r_pv[0] <= 1'b0;
            if (w_accept) begin
                r_buf <= w_merged;
                if (r_cnt == CntLast) begin
                    r_cnt   <= '0;
                    r_pd[0] <= w_merged;
                    r_pv[0] <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + CntW'(1);
                end
            end
            for (int unsigned i = 1; i <= REG_DEPTH_DATA; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pd[i] <= r_pd[i-1];
            end
        end
    end

    assign down_valid = r_pv[REG_DEPTH_DATA];
    assign down_data  = r_pd[REG_DEPTH_DATA];

endmodule

// File: tb/tb_flow_bus_deserializer.sv
// Bench for flow_bus_deserializer: three configurations share one stimulus stream and are
// checked every cycle against a transaction-level model, plus directed literal checks.
module tb_flow_bus_deserializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       enable;
    logic       up_valid;
    logic [7:0] up_data;
    logic       down_ready;

    logic        up_ready_w   [3];
    logic        down_valid_w [3];
    logic [15:0] down_data_w  [3];

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    // 0: defaults; 1: ready delayed 1, two extra data stages; 2: ready and enable ignored.
    flow_bus_deserializer u_dut0 (
        .clk(clk), .rst(rst), .enable(enable), .up_ready(up_ready_w[0]),
        .up_valid(up_valid), .up_data(up_data), .down_ready(down_ready),
        .down_valid(down_valid_w[0]), .down_data(down_data_w[0])
    );

    flow_bus_deserializer #(
        .REG_DEPTH_DATA(2), .REG_DEPTH_READY(1)
    ) u_dut1 (
        .clk(clk), .rst(rst), .enable(enable), .up_ready(up_ready_w[1]),
        .up_valid(up_valid), .up_data(up_data), .down_ready(down_ready),
        .down_valid(down_valid_w[1]), .down_data(down_data_w[1])
    );

    flow_bus_deserializer #(
        .USE_READY(0), .USE_ENABLE(0)
    ) u_dut2 (
        .clk(clk), .rst(rst), .enable(enable), .up_ready(up_ready_w[2]),
        .up_valid(up_valid), .up_data(up_data), .down_ready(down_ready),
        .down_valid(down_valid_w[2]), .down_data(down_data_w[2])
    );

    function automatic int rd_of(int i); return (i == 1) ? 1 : 0; endfunction
    function automatic int dd_of(int i); return (i == 1) ? 2 : 0; endfunction
    function automatic bit ur_of(int i); return (i != 2); endfunction
    function automatic bit ue_of(int i); return (i != 2); endfunction

    // Edge history: down_ready seen at edge k, and the most recent edge with reset low.
    int   n        = 0;
    int   last_rst = 0;
    logic dr_hist [1024];

    // Ready = source value from rd edges back, zero if a reset edge lies in that window.
    function automatic logic exp_ready(int i);
        int k;
        if (!rst) return 1'b0;
        if (ue_of(i) && !enable) return 1'b0;
        if (rd_of(i) == 0) return ur_of(i) ? down_ready : 1'b1;
        k = n - rd_of(i) + 1;
        if (k < 1 || k <= last_rst) return 1'b0;
        return ur_of(i) ? dr_hist[k % 1024] : 1'b1;
    endfunction

    // Transaction model: half-word store, future-pulse schedule by edge number, last word.
    int          nw      [3];
    logic [7:0]  first_w [3];
    logic        sched_v [3][8];
    logic [15:0] sched_d [3][8];
    logic        exp_dv  [3];
    logic [15:0] exp_dd  [3];
    logic        er      [3];

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) er[i] = exp_ready(i);
        n = n + 1;
        dr_hist[n % 1024] = down_ready;
        if (!rst) last_rst = n;
        for (int i = 0; i < 3; i++) begin
            if (!rst) begin
                nw[i]     = 0;
                exp_dv[i] = 1'b0;
                exp_dd[i] = 16'h0;
                for (int s = 0; s < 8; s++) sched_v[i][s] = 1'b0;
            end else begin
                if (up_valid && er[i]) begin
                    if (nw[i] == 0) begin
                        first_w[i] = up_data;
                        nw[i]      = 1;
                    end else begin
                        sched_v[i][(n + dd_of(i)) % 8] = 1'b1;
                        sched_d[i][(n + dd_of(i)) % 8] = 16'(first_w[i]) * 16'd256 + 16'(up_data);
                        nw[i] = 0;
                    end
                end
                exp_dv[i] = sched_v[i][n % 8];
                if (exp_dv[i]) begin
                    exp_dd[i] = sched_d[i][n % 8];
                    sched_v[i][n % 8] = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    // Model comparison on the falling edge, away from input changes and the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("up_ready[%0d]", i), 16'(up_ready_w[i]), 16'(exp_ready(i)));
                chk($sformatf("down_valid[%0d]", i), 16'(down_valid_w[i]), 16'(exp_dv[i]));
                chk($sformatf("down_data[%0d]", i), down_data_w[i], exp_dd[i]);
            end
        end
    end

    task automatic drive(input logic v, input logic [7:0] d);
        @(posedge clk);
        #2;
        up_valid = v;
        up_data  = d;
    endtask

    initial begin
        for (int k = 0; k < 1024; k++) dr_hist[k] = 1'b0;
        rst = 1'b0; enable = 1'b1; up_valid = 1'b1; up_data = 8'h5C; down_ready = 1'b1;
        repeat (3) @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("rst_up_ready", 16'(up_ready_w[i]), 16'h0);
            chk("rst_down_valid", 16'(down_valid_w[i]), 16'h0);
            chk("rst_down_data", down_data_w[i], 16'h0);
        end
        @(posedge clk); #2; rst = 1'b1; up_valid = 1'b0;
        drive(1'b0, 8'h00); drive(1'b0, 8'h00);

        // First pair after reset; deep pipeline copy three edges after the last word.
        drive(1'b1, 8'h12); drive(1'b1, 8'h34); drive(1'b0, 8'h00);
        @(negedge clk);
        chk("pair_valid", 16'(down_valid_w[0]), 16'h1);
        chk("pair_data", down_data_w[0], 16'h1234);
        @(negedge clk);
        chk("pipe_early", 16'(down_valid_w[1]), 16'h0);
        @(negedge clk);
        chk("pipe_pair_valid", 16'(down_valid_w[1]), 16'h1);
        chk("pipe_pair_data", down_data_w[1], 16'h1234);

        drive(1'b1, 8'h5A); drive(1'b1, 8'hA5); drive(1'b0, 8'h00);
        repeat (3) @(negedge clk);
        chk("pipe_5aa5_valid", 16'(down_valid_w[1]), 16'h1);
        chk("pipe_5aa5_data", down_data_w[1], 16'h5AA5);

        // Continuous streaming.
        drive(1'b1, 8'hA1); drive(1'b1, 8'hB2); drive(1'b1, 8'hC3);
        @(negedge clk);
        chk("stream1_valid", 16'(down_valid_w[0]), 16'h1);
        chk("stream1_data", down_data_w[0], 16'hA1B2);
        drive(1'b1, 8'hD4);
        @(negedge clk);
        chk("stream_gap_valid", 16'(down_valid_w[0]), 16'h0);
        drive(1'b0, 8'h00);
        @(negedge clk);
        chk("stream2_valid", 16'(down_valid_w[0]), 16'h1);
        chk("stream2_data", down_data_w[0], 16'hC3D4);

        // Enable gap mid-word.
        drive(1'b1, 8'h11);
        @(posedge clk); #2; enable = 1'b0;
        for (int c = 0; c < 10; c++) begin
            up_valid = c[0];
            up_data  = 8'($urandom);
            @(negedge clk);
            chk("gap_up_ready", 16'(up_ready_w[0]), 16'h0);
            chk("gap_valid", 16'(down_valid_w[0]), 16'h0);
            @(posedge clk); #2;
        end
        enable = 1'b1; up_valid = 1'b1; up_data = 8'h22;
        @(posedge clk); #2; up_valid = 1'b0;
        @(negedge clk);
        chk("gap_pair_valid", 16'(down_valid_w[0]), 16'h1);
        chk("gap_pair_data", down_data_w[0], 16'h1122);

        // Backpressure and ready lag.
        @(posedge clk); #2; down_ready = 1'b0; up_valid = 1'b1; up_data = 8'h99;
        @(negedge clk);
        chk("bp_up_ready0", 16'(up_ready_w[0]), 16'h0);
        chk("bp_up_ready2", 16'(up_ready_w[2]), 16'h1);
        repeat (3) begin
            @(negedge clk);
            chk("bp_up_ready1", 16'(up_ready_w[1]), 16'h0);
            chk("bp_valid0", 16'(down_valid_w[0]), 16'h0);
        end
        @(posedge clk); #2; down_ready = 1'b1; up_valid = 1'b0;
        @(negedge clk);
        chk("lag_up_ready0", 16'(up_ready_w[0]), 16'h1);
        chk("lag_up_ready1", 16'(up_ready_w[1]), 16'h0);
        @(negedge clk);
        chk("lag_up_ready1_after", 16'(up_ready_w[1]), 16'h1);

        // Reset discards a partial word.
        drive(1'b1, 8'h77); drive(1'b0, 8'h00);
        @(posedge clk); #2; rst = 1'b0;
        @(posedge clk); #2; rst = 1'b1;
        drive(1'b0, 8'h00); drive(1'b0, 8'h00);
        drive(1'b1, 8'h01); drive(1'b1, 8'h02); drive(1'b0, 8'h00);
        @(negedge clk);
        chk("prst_valid", 16'(down_valid_w[0]), 16'h1);
        chk("prst_data", down_data_w[0], 16'h0102);

        // Randomized traffic against the model.
        repeat (3000) begin
            @(posedge clk); #2;
            up_valid   = ($urandom_range(0, 3) != 0);
            up_data    = 8'($urandom);
            down_ready = ($urandom_range(0, 7) != 0);
            enable     = ($urandom_range(0, 9) != 0);
            rst        = ($urandom_range(0, 299) != 0);
        end
        @(posedge clk); #2; rst = 1'b1; up_valid = 1'b0;
        repeat (4) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
